// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory slave for the RV32I load/store unit.
// Accepts one request at a time, waits a fixed LATENCY, then presents a held
// response. Handles B/H/W/BU/HU sizing, extension and alignment/range faults.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // The wait counter is 4 bits wide, so larger latencies cannot be honoured.
    if (LATENCY > 15) begin : g_latency_check
        $error("dmem_responder: LATENCY must be in 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            we_q;
    logic [31:0]     addr_q;
    logic [2:0]      size_q;
    logic [31:0]     wdata_q;

    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            commit;
    logic            rsp_done;

    logic            c_we;
    logic [31:0]     c_addr;
    logic [2:0]      c_size;
    logic [31:0]     c_wdata;
    logic [29:0]     c_word;
    logic [1:0]      c_lane;
    logic [AW-1:0]   c_idx;
    logic            c_err;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [31:0]     ld_data;
    logic [3:0]      wmask;
    logic [31:0]     wplace;
    logic [31:0]     merged;

    // State register and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d   = CW'(LATENCY);
                    state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM-derived control: handshake flags and the commit strobe.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        accept    = req_valid && (state_q == S_IDLE);
        commit    = (state_d == S_RESP) && (state_q != S_RESP);
        rsp_done  = (state_q == S_RESP) && rsp_ready;
    end

    // Request latch; inputs are ignored after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
        end
    end

    // With zero latency the commit edge is the accept edge, so take the live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_size  = req_size;
            c_wdata = req_wdata;
        end else begin
            c_we    = we_q;
            c_addr  = addr_q;
            c_size  = size_q;
            c_wdata = wdata_q;
        end
    end

    // Fault detection: misalignment, illegal size encodings, sized stores, range.
    always_comb begin
        c_word = c_addr[31:2];
        c_lane = c_addr[1:0];
        c_idx  = AW'(c_word);
        c_err  = 1'b0;
        unique case (c_size)
            SZ_B:    c_err = 1'b0;
            SZ_H:    c_err = c_addr[0];
            SZ_W:    c_err = |c_lane;
            SZ_BU:   c_err = c_we;
            SZ_HU:   c_err = c_we | c_addr[0];
            default: c_err = 1'b1;
        endcase
        if ({2'b00, c_word} >= 32'(DEPTH_WORDS)) begin
            c_err = 1'b1;
        end
    end

    // Load extraction: shift the selected lane down, then extend.
    always_comb begin
        rd_word  = mem[c_idx];
        rd_shift = rd_word >> {c_lane, 3'b000};
        unique case (c_size)
            SZ_B:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_H:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            SZ_W:    ld_data = rd_word;
            SZ_BU:   ld_data = {24'h0, rd_shift[7:0]};
            SZ_HU:   ld_data = {16'h0, rd_shift[15:0]};
            default: ld_data = '0;
        endcase
    end

    // Store placement: replicate data across lanes and merge under a byte mask.
    always_comb begin
        unique case (c_size[1:0])
            2'b00: begin
                wmask  = 4'b0001 << c_lane;
                wplace = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                wmask  = c_addr[1] ? 4'b1100 : 4'b0011;
                wplace = {2{c_wdata[15:0]}};
            end
            default: begin
                wmask  = 4'b1111;
                wplace = c_wdata;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = wmask[b] ? wplace[b*8 +: 8] : rd_word[b*8 +: 8];
        end
    end

    // RAM array: not reset; written only on a fault-free store commit.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            mem[c_idx] <= merged;
        end
    end

    // Response registers: loaded on the commit edge, cleared on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (commit) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (c_err || c_we) ? 32'h0 : ld_data;
            rsp_err_q   <= c_err;
        end else if (rsp_done) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
